// File: rtl/display_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment display driver.
package display_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seven_segment_driver_if.sv
// Display-side bundle: frame inputs from the register file and the registered pin outputs.
interface seven_segment_driver_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_start;

  modport master (
    output value, dp, lz_blank, brightness,
    input  an_n, seg_n, dp_n, frame_start
  );

  modport slave (
    input  value, dp, lz_blank, brightness,
    output an_n, seg_n, dp_n, frame_start
  );
endinterface

// File: rtl/seven_segment_decode.sv
// Combinational nibble-to-segment decoder with forced blanking.
module seven_segment_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_segment_driver.sv
// Four-digit multiplexed seven-segment driver with guard gaps, PWM dimming and leading-zero blanking.
//   state   | meaning
//   S_GUARD | all anodes off for GUARD_CYCLES; frame inputs latched on digit 0's first guard cycle
//   S_DRIVE | digit_idx driven for DIGIT_CYCLES, anode gated by the PWM compare
module seven_segment_driver
  import display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_segment_driver_if.slave disp
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int SLOT_W     = $clog2(MAX_CYCLES);
  localparam logic [SLOT_W-1:0] DIGIT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] GUARD_LAST = SLOT_W'(GUARD_CYCLES - 1);

  state_e            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        digit_idx_q;
  logic [3:0]        pwm_q;
  logic [15:0]       value_q;
  logic [3:0]        dp_q;
  logic              lz_q;

  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_start_q;

  logic              frame_first;
  logic [3:0]        nib_zero;
  logic [3:0]        blank;
  logic [3:0]        nibble_cur;
  logic              blank_cur;
  logic [6:0]        seg_cur;

  assign frame_first = (state_q == S_GUARD) && (slot_q == '0) && (digit_idx_q == 2'd0);

  assign nib_zero[0] = (value_q[3:0]   == 4'h0);
  assign nib_zero[1] = (value_q[7:4]   == 4'h0);
  assign nib_zero[2] = (value_q[11:8]  == 4'h0);
  assign nib_zero[3] = (value_q[15:12] == 4'h0);

  // A digit is a leading zero only if it and every higher digit are zero; digit 0 always shows
  assign blank[3] = lz_q & nib_zero[3];
  assign blank[2] = lz_q & nib_zero[3] & nib_zero[2];
  assign blank[1] = lz_q & nib_zero[3] & nib_zero[2] & nib_zero[1];
  assign blank[0] = 1'b0;

  assign nibble_cur = value_q[{digit_idx_q, 2'b00} +: 4];
  assign blank_cur  = blank[digit_idx_q];

  seven_segment_decode u_decode (
    .nibble_i (nibble_cur),
    .blank_i  (blank_cur),
    .seg_n_o  (seg_cur)
  );

  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (state_q == S_DRIVE) begin
      seg_d  = seg_cur;
      dp_n_d = ~dp_q[digit_idx_q];
      if (!blank_cur && (pwm_q < disp.brightness)) begin
        an_d[digit_idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_GUARD;
      slot_q        <= '0;
      digit_idx_q   <= 2'd0;
      pwm_q         <= 4'd0;
      value_q       <= 16'h0000;
      dp_q          <= 4'h0;
      lz_q          <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pwm_q         <= pwm_q + 4'd1;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_first;
      if (frame_first) begin
        value_q <= disp.value;
        dp_q    <= disp.dp;
        lz_q    <= disp.lz_blank;
      end
      case (state_q)
        S_GUARD: begin
          if (slot_q == GUARD_LAST) begin
            state_q <= S_DRIVE;
            slot_q  <= '0;
          end else begin
            slot_q  <= slot_q + SLOT_W'(1);
          end
        end
        S_DRIVE: begin
          if (slot_q == DIGIT_LAST) begin
            state_q     <= S_GUARD;
            slot_q      <= '0;
            digit_idx_q <= digit_idx_q + 2'd1;
          end else begin
            slot_q      <= slot_q + SLOT_W'(1);
          end
        end
        default: begin
          state_q <= S_GUARD;
          slot_q  <= '0;
        end
      endcase
    end
  end

  assign disp.an_n        = an_q;
  assign disp.seg_n       = seg_q;
  assign disp.dp_n        = dp_n_q;
  assign disp.frame_start = frame_start_q;

endmodule
